// File: rtl/sparc_glue_pkg.sv
// Shared constants and decode helper for the SPARC datapath glue decoders.
// Both decoder widths use the one helper; narrower decoders keep the low bits of its result.
package sparc_glue_pkg;

   localparam int SEL_W_A = 2;
   localparam int SEL_W_B = 5;
   localparam int OUT_W_A = 2 ** SEL_W_A;
   localparam int OUT_W_B = 2 ** SEL_W_B;

   // Widest decode supported by the helper; narrower decoders zero-extend their select.
   localparam int MAX_SEL_W = SEL_W_B;
   localparam int MAX_OUT_W = OUT_W_B;

   // Gated one-hot: all zeros when disabled, so an unknown select can never leak through.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                   input logic                 en);
      logic [MAX_OUT_W-1:0] vec;
      vec = '0;
      if (en) begin
         vec[sel] = 1'b1;
      end
      return vec;
   endfunction

endpackage : sparc_glue_pkg

// File: rtl/sparc_onehot_dec.sv
// Enable-gated binary-to-one-hot decoder with a registered output.
// The register clears asynchronously on Reset and otherwise loads the gated decode every edge.
module sparc_onehot_dec
   import sparc_glue_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [SEL_W-1:0]    sel,
   input  logic                en,
   output logic [2**SEL_W-1:0] q
);

   localparam int OUT_W = 2 ** SEL_W;

   logic [MAX_SEL_W-1:0] sel_ext;
   logic [MAX_OUT_W-1:0] dec_full;
   logic [OUT_W-1:0]     q_d;
   logic [OUT_W-1:0]     q_q;

   assign sel_ext  = MAX_SEL_W'(sel);
   assign dec_full = onehot(sel_ext, en);

   // Upper helper bits are always zero for a narrower decoder.
   generate
      if (OUT_W < MAX_OUT_W) begin : g_narrow
         logic unused_hi;
         assign unused_hi = ^dec_full[MAX_OUT_W-1:OUT_W];
      end
   endgenerate

   always_comb begin
      q_d = dec_full[OUT_W-1:0];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : sparc_onehot_dec

// File: rtl/sparc_decoders.sv
// SPARC glue decoders: independent 2-to-4 and 5-to-32 registered one-hot decoders.
// Wiring only; all state lives in the two decoder instances.
module sparc_decoders
   import sparc_glue_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic [SEL_W_A-1:0] Ein2x4,
   input  logic               Ld2x4,
   output logic [OUT_W_A-1:0] Eout2x4,
   input  logic [SEL_W_B-1:0] Ein5x32,
   input  logic               Ld5x32,
   output logic [OUT_W_B-1:0] Eout5x32
);

   sparc_onehot_dec #(.SEL_W(SEL_W_A)) u_dec_a (
      .Clk   (Clk),
      .Reset (Reset),
      .sel   (Ein2x4),
      .en    (Ld2x4),
      .q     (Eout2x4)
   );

   sparc_onehot_dec #(.SEL_W(SEL_W_B)) u_dec_b (
      .Clk   (Clk),
      .Reset (Reset),
      .sel   (Ein5x32),
      .en    (Ld5x32),
      .q     (Eout5x32)
   );

endmodule : sparc_decoders

// File: tb/tb_sparc_decoders.sv
// Self-checking bench for sparc_decoders: directed scenarios plus randomized traffic
// compared against a power-of-two reference model.
module tb_sparc_decoders;

   logic        Clk;
   logic        Reset;
   logic [1:0]  Ein2x4;
   logic        Ld2x4;
   logic [3:0]  Eout2x4;
   logic [4:0]  Ein5x32;
   logic        Ld5x32;
   logic [31:0] Eout5x32;

   int checks;
   int failures;

   sparc_decoders dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Ein2x4   (Ein2x4),
      .Ld2x4    (Ld2x4),
      .Eout2x4  (Eout2x4),
      .Ein5x32  (Ein5x32),
      .Ld5x32   (Ld5x32),
      .Eout5x32 (Eout5x32)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: enable gates a single power-of-two bit at the select position.
   function automatic logic [3:0] model_a(input int sel, input bit ld);
      return ld ? 4'(2 ** (sel % 4)) : 4'h0;
   endfunction

   function automatic logic [31:0] model_b(input int sel, input bit ld);
      return ld ? 32'(64'd2 ** (sel % 32)) : 32'h0;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset   = 1'b1;
      Ld2x4   = 1'b1;
      Ld5x32  = 1'b1;
      Ein2x4  = 2'd1;
      Ein5x32 = 5'd7;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (Eout2x4 !== 4'h0 || Eout5x32 !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d a=%h b=%h required a=0 b=0", i, Eout2x4, Eout5x32);
         end else
            $display("reset_hold cyc=%0d a=%h b=%h", i, Eout2x4, Eout5x32);
      end
      Reset = 1'b0;
      tick();
      checks++;
      if (Eout2x4 !== 4'b0010 || Eout5x32 !== 32'h0000_0080) begin
         failures++;
         $display("FAIL reset_release a=%h b=%h required a=2 b=00000080", Eout2x4, Eout5x32);
      end else
         $display("reset_release a=%h b=%h", Eout2x4, Eout5x32);
   endtask

   task automatic test_sweep_a();
      logic [3:0] exp_a;
      Ld2x4  = 1'b1;
      Ld5x32 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         Ein2x4 = 2'(i % 4);
         exp_a  = model_a(i, 1'b1);
         tick();
         checks++;
         if (Eout2x4 !== exp_a || Eout5x32 !== 32'h0) begin
            failures++;
            $display("FAIL sweep_a sel=%0d a=%b b=%h required a=%b b=0", i % 4, Eout2x4, Eout5x32, exp_a);
         end else
            $display("sweep_a sel=%0d a=%b", i % 4, Eout2x4);
      end
   endtask

   task automatic test_sweep_b();
      logic [31:0] exp_b;
      Ld2x4  = 1'b0;
      Ld5x32 = 1'b1;
      for (int i = 0; i < 33; i++) begin
         Ein5x32 = 5'(i % 32);
         exp_b   = model_b(i, 1'b1);
         tick();
         checks++;
         if (Eout5x32 !== exp_b || Eout2x4 !== 4'h0) begin
            failures++;
            $display("FAIL sweep_b sel=%0d b=%h a=%h required b=%h a=0", i % 32, Eout5x32, Eout2x4, exp_b);
         end else
            $display("sweep_b sel=%0d b=%h", i % 32, Eout5x32);
      end
   endtask

   task automatic test_disabled();
      Ld2x4  = 1'b0;
      Ld5x32 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i % 3 == 2) begin
            Ein2x4  = 2'bxx;
            Ein5x32 = 5'bxxxxx;
         end else begin
            Ein2x4  = 2'($urandom_range(0, 3));
            Ein5x32 = 5'($urandom_range(0, 31));
         end
         tick();
         checks++;
         if (Eout2x4 !== 4'h0 || Eout5x32 !== 32'h0) begin
            failures++;
            $display("FAIL disabled step=%0d a=%h b=%h required a=0 b=0", i, Eout2x4, Eout5x32);
         end else
            $display("disabled step=%0d a=%h b=%h", i, Eout2x4, Eout5x32);
      end
   endtask

   task automatic test_independent();
      Ein2x4  = 2'd2;
      Ein5x32 = 5'd17;
      Ld2x4   = 1'b1;
      Ld5x32  = 1'b0;
      tick();
      checks++;
      if (Eout2x4 !== 4'b0100 || Eout5x32 !== 32'h0) begin
         failures++;
         $display("FAIL indep_a_on a=%b b=%h required a=0100 b=0", Eout2x4, Eout5x32);
      end else
         $display("indep_a_on a=%b b=%h", Eout2x4, Eout5x32);
      Ld2x4  = 1'b0;
      Ld5x32 = 1'b1;
      tick();
      checks++;
      if (Eout2x4 !== 4'h0 || Eout5x32 !== 32'h0002_0000) begin
         failures++;
         $display("FAIL indep_b_on a=%b b=%h required a=0000 b=00020000", Eout2x4, Eout5x32);
      end else
         $display("indep_b_on a=%b b=%h", Eout2x4, Eout5x32);
   endtask

   task automatic test_async_reset();
      Ld2x4   = 1'b1;
      Ein2x4  = 2'd3;
      Ld5x32  = 1'b1;
      Ein5x32 = 5'd8;
      tick();
      checks++;
      if (Eout5x32 !== 32'h0000_0100 || Eout2x4 !== 4'b1000) begin
         failures++;
         $display("FAIL async_setup a=%b b=%h required a=1000 b=00000100", Eout2x4, Eout5x32);
      end else
         $display("async_setup a=%b b=%h", Eout2x4, Eout5x32);
      // Assert mid-cycle, well before the next rising edge.
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if (Eout5x32 !== 32'h0 || Eout2x4 !== 4'h0) begin
         failures++;
         $display("FAIL async_clear a=%b b=%h required a=0 b=0", Eout2x4, Eout5x32);
      end else
         $display("async_clear a=%b b=%h", Eout2x4, Eout5x32);
      tick();
      Reset = 1'b0;
      #2;
      checks++;
      if (Eout5x32 !== 32'h0 || Eout2x4 !== 4'h0) begin
         failures++;
         $display("FAIL async_after_release a=%b b=%h required a=0 b=0", Eout2x4, Eout5x32);
      end else
         $display("async_after_release a=%b b=%h", Eout2x4, Eout5x32);
      tick();
      checks++;
      if (Eout5x32 !== 32'h0000_0100 || Eout2x4 !== 4'b1000) begin
         failures++;
         $display("FAIL async_first_edge a=%b b=%h required a=1000 b=00000100", Eout2x4, Eout5x32);
      end else
         $display("async_first_edge a=%b b=%h", Eout2x4, Eout5x32);
   endtask

   task automatic test_random();
      int          sa, sb;
      bit          la, lb;
      logic [3:0]  exp_a;
      logic [31:0] exp_b;
      for (int i = 0; i < 40; i++) begin
         sa = int'($urandom_range(0, 3));
         sb = int'($urandom_range(0, 31));
         la = 1'($urandom_range(0, 1));
         lb = 1'($urandom_range(0, 1));
         Ein2x4  = 2'(sa);
         Ein5x32 = 5'(sb);
         Ld2x4   = la;
         Ld5x32  = lb;
         exp_a   = model_a(sa, la);
         exp_b   = model_b(sb, lb);
         tick();
         checks++;
         if (Eout2x4 !== exp_a || Eout5x32 !== exp_b) begin
            failures++;
            $display("FAIL random i=%0d a=%b b=%h required a=%b b=%h", i, Eout2x4, Eout5x32, exp_a, exp_b);
         end else
            $display("random i=%0d sa=%0d la=%0d sb=%0d lb=%0d a=%b b=%h", i, sa, la, sb, lb, Eout2x4, Eout5x32);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      Reset    = 1'b1;
      Ein2x4   = '0;
      Ld2x4    = 1'b0;
      Ein5x32  = '0;
      Ld5x32   = 1'b0;
      #1;
      test_reset();
      test_sweep_a();
      test_sweep_b();
      test_disabled();
      test_independent();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sparc_decoders
